// File: rtl/estimate_pkg.sv
// Shared types and constants for the estimate-array command sequencer.
// Command encodings match the array's com port.
package estimate_pkg;

    typedef enum logic [2:0] {
        CMD_INI   = 3'd0,
        CMD_ACC   = 3'd1,
        CMD_POOL  = 3'd2,
        CMD_NORM  = 3'd3,
        CMD_ACTIV = 3'd4,
        CMD_ACC8  = 3'd5,
        CMD_NORM8 = 3'd6,
        CMD_NOP   = 3'd7
    } com_t;

    // Cycles from com=ACTIV on the array port until activ is valid.
    localparam int unsigned ACTIV_LAT = 3;

    typedef enum logic [2:0] {
        StIdle,
        StIni,
        StAcc,
        StPool,
        StNorm,
        StActiv,
        StDrain,
        StDone
    } seq_state_t;

endpackage

// File: rtl/estimate_seq_if.sv
// Array/input-buffer bus between the sequencer (master) and the estimate array plus
// its activation buffer (slave).
interface estimate_seq_if #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned IBUF_AW = 10
);
    logic [IBUF_AW-1:0] ibuf_addr;
    logic [31:0]        ibuf_rdata;
    logic [2:0]         com;
    logic [ADDR_W-1:0]  addr;
    logic [31:0]        data;
    logic [31:0]        activ;

    modport master (
        output ibuf_addr, com, addr, data,
        input  ibuf_rdata, activ
    );

    modport slave (
        input  ibuf_addr, com, addr, data,
        output ibuf_rdata, activ
    );
endinterface

// File: rtl/estimate_seq_capture.sv
// Tracks each ACTIV command through the array latency and latches the resulting
// activ word, pulsing out_valid the cycle after the capture edge.
module estimate_seq_capture
    import estimate_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  com_t        com_i,
    input  logic [31:0] activ_i,
    output logic        out_valid_o,
    output logic [31:0] out_data_o
);

    logic [ACTIV_LAT-1:0] pipe_q, pipe_d;
    logic                 valid_q, valid_d;
    logic [31:0]          data_q, data_d;

    always_comb begin
        pipe_d  = {pipe_q[ACTIV_LAT-2:0], com_i == CMD_ACTIV};
        valid_d = pipe_q[ACTIV_LAT-1];
        data_d  = pipe_q[ACTIV_LAT-1] ? activ_i : data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            pipe_q  <= pipe_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/estimate_seq.sv
// Layer command sequencer for the 32-lane estimate array: per output group issues
// INI / ACC x n_acc (per pool position) / POOL / NORM / ACTIV and captures the result.
module estimate_seq
    import estimate_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned IBUF_AW = 10,
    parameter int unsigned CNT_W   = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               cfg_mode8,
    input  logic [CNT_W-1:0]   cfg_n_acc,
    input  logic [CNT_W-1:0]   cfg_n_pool,
    input  logic [CNT_W-1:0]   cfg_n_group,
    input  logic [ADDR_W-1:0]  cfg_pbase,
    input  logic [IBUF_AW-1:0] cfg_ibase,
    estimate_seq_if.master     bus,
    output logic               out_valid,
    output logic [31:0]        out_data,
    output logic               busy,
    output logic               done
);

    seq_state_t         state_q, state_d;
    logic               mode8_q, mode8_d;
    logic [CNT_W-1:0]   n_acc_q, n_acc_d;
    logic [CNT_W-1:0]   n_pool_q, n_pool_d;
    logic [CNT_W-1:0]   n_group_q, n_group_d;
    logic [IBUF_AW-1:0] ibase_q, ibase_d;
    logic [CNT_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0]   p_q, p_d;
    logic [CNT_W-1:0]   g_q, g_d;
    logic [ADDR_W-1:0]  gbase_q, gbase_d;
    logic [IBUF_AW-1:0] iptr_q, iptr_d;
    com_t               com_q, com_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               cap_valid;

    always_comb begin
        state_d   = state_q;
        mode8_d   = mode8_q;
        n_acc_d   = n_acc_q;
        n_pool_d  = n_pool_q;
        n_group_d = n_group_q;
        ibase_d   = ibase_q;
        k_d       = k_q;
        p_d       = p_q;
        g_d       = g_q;
        gbase_d   = gbase_q;
        iptr_d    = iptr_q;
        com_d     = CMD_NOP;
        addr_d    = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // A zero count would never terminate its loop; run it once instead.
                    mode8_d   = cfg_mode8;
                    n_acc_d   = (cfg_n_acc == '0) ? CNT_W'(1) : cfg_n_acc;
                    n_pool_d  = (cfg_n_pool == '0) ? CNT_W'(1) : cfg_n_pool;
                    n_group_d = (cfg_n_group == '0) ? CNT_W'(1) : cfg_n_group;
                    ibase_d   = cfg_ibase;
                    iptr_d    = cfg_ibase;
                    gbase_d   = cfg_pbase;
                    k_d       = '0;
                    p_d       = '0;
                    g_d       = '0;
                    state_d   = StIni;
                end
            end
            StIni: begin
                com_d   = CMD_INI;
                state_d = StAcc;
            end
            StAcc: begin
                com_d  = mode8_q ? CMD_ACC8 : CMD_ACC;
                addr_d = gbase_q + ADDR_W'(k_q);
                iptr_d = iptr_q + IBUF_AW'(1);
                if (k_q == n_acc_q - CNT_W'(1)) begin
                    k_d     = '0;
                    state_d = StPool;
                end else begin
                    k_d = k_q + CNT_W'(1);
                end
            end
            StPool: begin
                com_d = CMD_POOL;
                if (p_q != n_pool_q - CNT_W'(1)) begin
                    p_d     = p_q + CNT_W'(1);
                    state_d = StAcc;
                end else begin
                    p_d     = '0;
                    state_d = StNorm;
                end
            end
            StNorm: begin
                com_d   = mode8_q ? CMD_NORM8 : CMD_NORM;
                addr_d  = gbase_q + ADDR_W'(n_acc_q);
                state_d = StActiv;
            end
            StActiv: begin
                com_d   = CMD_ACTIV;
                state_d = StDrain;
            end
            StDrain: begin
                // Hold until the group's activ word is out so groups never overlap.
                if (cap_valid) begin
                    if (g_q != n_group_q - CNT_W'(1)) begin
                        g_d     = g_q + CNT_W'(1);
                        gbase_d = gbase_q + ADDR_W'(n_acc_q) + ADDR_W'(1);
                        iptr_d  = ibase_q;
                        state_d = StIni;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            mode8_q   <= 1'b0;
            n_acc_q   <= '0;
            n_pool_q  <= '0;
            n_group_q <= '0;
            ibase_q   <= '0;
            k_q       <= '0;
            p_q       <= '0;
            g_q       <= '0;
            gbase_q   <= '0;
            iptr_q    <= '0;
            com_q     <= CMD_NOP;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            mode8_q   <= mode8_d;
            n_acc_q   <= n_acc_d;
            n_pool_q  <= n_pool_d;
            n_group_q <= n_group_d;
            ibase_q   <= ibase_d;
            k_q       <= k_d;
            p_q       <= p_d;
            g_q       <= g_d;
            gbase_q   <= gbase_d;
            iptr_q    <= iptr_d;
            com_q     <= com_d;
            addr_q    <= addr_d;
        end
    end

    // The buffer read launched during an ACC issue lands alongside the registered com.
    assign bus.ibuf_addr = iptr_q;
    assign bus.com       = com_q;
    assign bus.addr      = addr_q;
    assign bus.data      = (com_q == CMD_ACC || com_q == CMD_ACC8) ? bus.ibuf_rdata : '0;

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);

    estimate_seq_capture u_capture (
        .clk         (clk),
        .reset       (reset),
        .com_i       (com_q),
        .activ_i     (bus.activ),
        .out_valid_o (cap_valid),
        .out_data_o  (out_data)
    );

    assign out_valid = cap_valid;

endmodule

// File: tb/tb_estimate_seq.sv
// Directed bench for estimate_seq: stub input buffer and array, trace the command
// stream and compare against hand-written expected sequences.
module tb_estimate_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        cfg_mode8;
    logic [11:0] cfg_n_acc, cfg_n_pool, cfg_n_group;
    logic [15:0] cfg_pbase;
    logic [9:0]  cfg_ibase;
    logic        out_valid;
    logic [31:0] out_data;
    logic        busy, done;

    estimate_seq_if #(.ADDR_W(16), .IBUF_AW(10)) bus ();

    estimate_seq #(.ADDR_W(16), .IBUF_AW(10), .CNT_W(12)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cfg_mode8   (cfg_mode8),
        .cfg_n_acc   (cfg_n_acc),
        .cfg_n_pool  (cfg_n_pool),
        .cfg_n_group (cfg_n_group),
        .cfg_pbase   (cfg_pbase),
        .cfg_ibase   (cfg_ibase),
        .bus         (bus),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    always_ff @(posedge clk) bus.ibuf_rdata <= mem[bus.ibuf_addr];

    logic [31:0] act_tab [2] = '{32'hA5A5_A5A5, 32'h0F0F_0F0F};

    int n_vec = 0;
    int n_err = 0;

    // Observed trace
    logic [2:0]  q_com [$];
    logic [15:0] q_addr[$];
    logic [31:0] q_data[$];
    int          q_cyc [$];
    int          act_cyc[$];
    int          ov_cyc[$];
    logic [31:0] ov_dat[$];
    int          done_cnt, done_cyc, nact;

    // Expected trace
    logic [2:0]  e_com [$];
    bit          e_ca  [$];
    logic [15:0] e_addr[$];
    logic [31:0] e_data[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic exp_clear();
        e_com.delete(); e_ca.delete(); e_addr.delete(); e_data.delete();
    endtask

    task automatic exp_cmd(input logic [2:0] c, input bit ca, input logic [15:0] a,
                           input logic [31:0] d);
        e_com.push_back(c); e_ca.push_back(ca); e_addr.push_back(a); e_data.push_back(d);
    endtask

    task automatic run_layer(input logic m8, input logic [11:0] na, input logic [11:0] np,
                             input logic [11:0] ng, input logic [15:0] pb,
                             input logic [9:0] ib, input int poke);
        q_com.delete(); q_addr.delete(); q_data.delete(); q_cyc.delete();
        act_cyc.delete(); ov_cyc.delete(); ov_dat.delete();
        done_cnt = 0; done_cyc = 0; nact = 0;
        @(negedge clk);
        cfg_mode8 = m8; cfg_n_acc = na; cfg_n_pool = np; cfg_n_group = ng;
        cfg_pbase = pb; cfg_ibase = ib;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            start = (i == poke);
            if (i == poke) cfg_n_acc = 12'd5;
            if (bus.com != 3'd7) begin
                q_com.push_back(bus.com); q_addr.push_back(bus.addr);
                q_data.push_back(bus.data); q_cyc.push_back(i);
            end
            if (bus.com == 3'd4) begin
                act_cyc.push_back(i);
                bus.activ = act_tab[nact % 2];
                nact++;
            end
            if (out_valid) begin
                ov_cyc.push_back(i); ov_dat.push_back(out_data);
            end
            if (done) begin
                done_cnt++; done_cyc = i;
            end
            if (done_cnt > 0 && i >= done_cyc + 3) break;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_run(input string tag, input int n_ov);
        int gaps;
        check_eq({tag, "_len"}, 32'(q_com.size()), 32'(e_com.size()));
        for (int i = 0; i < e_com.size() && i < q_com.size(); i++) begin
            check_eq($sformatf("%s_com%0d", tag, i), 32'(q_com[i]), 32'(e_com[i]));
            if (e_ca[i]) check_eq($sformatf("%s_addr%0d", tag, i), 32'(q_addr[i]), 32'(e_addr[i]));
            check_eq($sformatf("%s_data%0d", tag, i), q_data[i], e_data[i]);
        end
        // Within a group every command follows its predecessor on the next cycle.
        gaps = 0;
        for (int i = 1; i < q_com.size(); i++)
            if (q_com[i] != 3'd0 && q_cyc[i] - q_cyc[i-1] != 1) gaps++;
        check_eq({tag, "_gaps"}, 32'(gaps), 32'd0);
        check_eq({tag, "_ov_cnt"}, 32'(ov_cyc.size()), 32'(n_ov));
        for (int j = 0; j < ov_cyc.size() && j < act_cyc.size() && j < n_ov; j++) begin
            check_eq($sformatf("%s_ov_lat%0d", tag, j), 32'(ov_cyc[j] - act_cyc[j]), 32'd4);
            check_eq($sformatf("%s_ov_dat%0d", tag, j), ov_dat[j], act_tab[j]);
        end
        check_eq({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        if (ov_cyc.size() > 0)
            check_eq({tag, "_done_lat"}, 32'(done_cyc - ov_cyc[ov_cyc.size()-1]), 32'd1);
        check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int cnt_ov, cnt_done, cnt_cmd;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h5A00_0000 + i;
        reset = 1'b1; start = 1'b0; cfg_mode8 = 1'b0;
        cfg_n_acc = '0; cfg_n_pool = '0; cfg_n_group = '0; cfg_pbase = '0; cfg_ibase = '0;
        bus.activ = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_com",      32'(bus.com),       32'd7);
        check_eq("rst_addr",     32'(bus.addr),      32'd0);
        check_eq("rst_ibuf",     32'(bus.ibuf_addr), 32'd0);
        check_eq("rst_ov",       32'(out_valid),     32'd0);
        check_eq("rst_odata",    out_data,           32'd0);
        check_eq("rst_busy",     32'(busy),          32'd0);
        check_eq("rst_done",     32'(done),          32'd0);
        reset = 1'b0;

        // Binary, single pool position
        run_layer(1'b0, 12'd2, 12'd1, 12'd1, 16'h10, 10'd0, -1);
        exp_clear();
        exp_cmd(3'd0, 0, 16'h0,  32'h0);
        exp_cmd(3'd1, 1, 16'h10, 32'h5A00_0000);
        exp_cmd(3'd1, 1, 16'h11, 32'h5A00_0001);
        exp_cmd(3'd2, 0, 16'h0,  32'h0);
        exp_cmd(3'd3, 1, 16'h12, 32'h0);
        exp_cmd(3'd4, 0, 16'h0,  32'h0);
        check_run("bin1", 1);

        // Two pool positions: weights reused, input words continue
        run_layer(1'b0, 12'd2, 12'd2, 12'd1, 16'h10, 10'd0, -1);
        exp_clear();
        exp_cmd(3'd0, 0, 16'h0,  32'h0);
        exp_cmd(3'd1, 1, 16'h10, 32'h5A00_0000);
        exp_cmd(3'd1, 1, 16'h11, 32'h5A00_0001);
        exp_cmd(3'd2, 0, 16'h0,  32'h0);
        exp_cmd(3'd1, 1, 16'h10, 32'h5A00_0002);
        exp_cmd(3'd1, 1, 16'h11, 32'h5A00_0003);
        exp_cmd(3'd2, 0, 16'h0,  32'h0);
        exp_cmd(3'd3, 1, 16'h12, 32'h0);
        exp_cmd(3'd4, 0, 16'h0,  32'h0);
        check_run("pool2", 1);

        // mode8
        run_layer(1'b1, 12'd2, 12'd1, 12'd1, 16'h10, 10'd0, -1);
        exp_clear();
        exp_cmd(3'd0, 0, 16'h0,  32'h0);
        exp_cmd(3'd5, 1, 16'h10, 32'h5A00_0000);
        exp_cmd(3'd5, 1, 16'h11, 32'h5A00_0001);
        exp_cmd(3'd2, 0, 16'h0,  32'h0);
        exp_cmd(3'd6, 1, 16'h12, 32'h0);
        exp_cmd(3'd4, 0, 16'h0,  32'h0);
        check_run("m8", 1);

        // Two groups
        run_layer(1'b0, 12'd2, 12'd1, 12'd2, 16'h10, 10'd0, -1);
        exp_clear();
        exp_cmd(3'd0, 0, 16'h0,  32'h0);
        exp_cmd(3'd1, 1, 16'h10, 32'h5A00_0000);
        exp_cmd(3'd1, 1, 16'h11, 32'h5A00_0001);
        exp_cmd(3'd2, 0, 16'h0,  32'h0);
        exp_cmd(3'd3, 1, 16'h12, 32'h0);
        exp_cmd(3'd4, 0, 16'h0,  32'h0);
        exp_cmd(3'd0, 0, 16'h0,  32'h0);
        exp_cmd(3'd1, 1, 16'h13, 32'h5A00_0000);
        exp_cmd(3'd1, 1, 16'h14, 32'h5A00_0001);
        exp_cmd(3'd2, 0, 16'h0,  32'h0);
        exp_cmd(3'd3, 1, 16'h15, 32'h0);
        exp_cmd(3'd4, 0, 16'h0,  32'h0);
        check_run("grp2", 2);
        if (q_cyc.size() > 6 && ov_cyc.size() > 0)
            check_eq("grp2_ini_gap", 32'(q_cyc[6] - ov_cyc[0]), 32'd2);

        // start while busy (with altered config) is ignored
        run_layer(1'b0, 12'd2, 12'd1, 12'd1, 16'h10, 10'd0, 3);
        exp_clear();
        exp_cmd(3'd0, 0, 16'h0,  32'h0);
        exp_cmd(3'd1, 1, 16'h10, 32'h5A00_0000);
        exp_cmd(3'd1, 1, 16'h11, 32'h5A00_0001);
        exp_cmd(3'd2, 0, 16'h0,  32'h0);
        exp_cmd(3'd3, 1, 16'h12, 32'h0);
        exp_cmd(3'd4, 0, 16'h0,  32'h0);
        check_run("poke", 1);

        // All counts zero behave as one; nonzero ibase
        run_layer(1'b0, 12'd0, 12'd0, 12'd0, 16'h40, 10'h20, -1);
        exp_clear();
        exp_cmd(3'd0, 0, 16'h0,  32'h0);
        exp_cmd(3'd1, 1, 16'h40, 32'h5A00_0020);
        exp_cmd(3'd2, 0, 16'h0,  32'h0);
        exp_cmd(3'd3, 1, 16'h41, 32'h0);
        exp_cmd(3'd4, 0, 16'h0,  32'h0);
        check_run("zero", 1);

        // Reset mid-layer with an ACTIV in flight
        @(negedge clk);
        cfg_mode8 = 1'b0; cfg_n_acc = 12'd2; cfg_n_pool = 12'd1; cfg_n_group = 12'd1;
        cfg_pbase = 16'h10; cfg_ibase = 10'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("mid_busy", 32'(busy), 32'd1);
        check_eq("mid_com", 32'(bus.com), 32'd4);
        #2 reset = 1'b1;
        @(negedge clk);
        check_eq("mrst_com",   32'(bus.com),   32'd7);
        check_eq("mrst_busy",  32'(busy),      32'd0);
        check_eq("mrst_ov",    32'(out_valid), 32'd0);
        check_eq("mrst_odata", out_data,       32'd0);
        check_eq("mrst_ibuf",  32'(bus.ibuf_addr), 32'd0);
        reset = 1'b0;
        cnt_ov = 0; cnt_done = 0; cnt_cmd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) cnt_ov++;
            if (done) cnt_done++;
            if (bus.com != 3'd7) cnt_cmd++;
        end
        check_eq("post_rst_ov",   32'(cnt_ov),   32'd0);
        check_eq("post_rst_done", 32'(cnt_done), 32'd0);
        check_eq("post_rst_cmd",  32'(cnt_cmd),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
